// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential packed-BCD to binary converter.
// One digit is folded into the accumulator per clock, most significant digit first,
// using acc*10 + digit. A start/ready handshake frames each request and a sticky
// flag reports any nibble above 9. value/error only change at completion or reset.
module bcd_to_binary #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [WIDTH-1:0]      value,
  output logic                  ready,
  output logic                  error
);

  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state, state_n;
  logic [4*DIGITS-1:0]   sreg, sreg_n;
  logic [WIDTH-1:0]      acc, acc_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  err_acc, err_n;
  logic [WIDTH-1:0]      value_n;
  logic                  error_n;
  logic [3:0]            digit;
  logic [WIDTH-1:0]      acc_x10;

  // The digit being folded in is always the top nibble of the shift register
  assign digit   = sreg[4*DIGITS-1 -: 4];
  // Multiply by ten as shift-and-add, wrapping at WIDTH bits
  assign acc_x10 = WIDTH'(acc << 3) + WIDTH'(acc << 1);
  assign ready   = (state == IDLE);

  // Next-state and datapath update: accept in IDLE, fold one digit per RUN cycle
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    acc_n   = acc;
    cnt_n   = cnt;
    err_n   = err_acc;
    value_n = value;
    error_n = error;
    case (state)
      IDLE: begin
        if (start) begin
          sreg_n  = bcd;
          acc_n   = '0;
          cnt_n   = CW'(DIGITS);
          err_n   = 1'b0;
          state_n = RUN;
        end
      end
      RUN: begin
        acc_n  = acc_x10 + WIDTH'(digit);
        sreg_n = sreg << 4;
        err_n  = err_acc | (digit > 4'd9);
        cnt_n  = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          value_n = acc_n;
          error_n = err_n;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; reset abandons any conversion in flight without completing it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sreg    <= '0;
      acc     <= '0;
      cnt     <= '0;
      err_acc <= 1'b0;
      value   <= '0;
      error   <= 1'b0;
    end else begin
      state   <= state_n;
      sreg    <= sreg_n;
      acc     <= acc_n;
      cnt     <= cnt_n;
      err_acc <= err_n;
      value   <= value_n;
      error   <= error_n;
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: fixed vector table, random vectors
// against a decimal-weight reference model, and hand-written handshake sequences.
module tb_bcd_to_binary;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bcd;
  logic [13:0] value;
  logic        ready;
  logic        error;

  int tests;
  int failures;

  bcd_to_binary #(.DIGITS(4), .WIDTH(14)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bcd   (bcd),
    .value (value),
    .ready (ready),
    .error (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] val;
    logic        err;
  } vec_t;

  vec_t vecs[7];

  // Reference: weight each nibble by its decimal position, wrap at 14 bits
  function automatic int refValue(input logic [15:0] b);
    int sum;
    int weight;
    sum = 0;
    weight = 1;
    for (int i = 0; i < 4; i++) begin
      sum = sum + int'(b[4*i +: 4]) * weight;
      weight = weight * 10;
    end
    return sum % 16384;
  endfunction

  function automatic logic refError(input logic [15:0] b);
    logic e;
    e = 1'b0;
    for (int i = 0; i < 4; i++)
      if (b[4*i +: 4] > 4'd9) e = 1'b1;
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Issue a one-cycle start with operand b, then count busy cycles until ready
  task automatic applyStimulus(input logic [15:0] b, output int busy);
    @(negedge clk);
    bcd   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy  = 0;
    while (ready == 1'b0 && busy < 20) begin
      busy++;
      @(negedge clk);
    end
  endtask

  task automatic convertAndCheck(input string name, input logic [15:0] b,
                                 input int expVal, input logic expErr);
    int busy;
    applyStimulus(b, busy);
    checkOutput({name, " busy"}, busy, 4);
    checkOutput({name, " value"}, int'(value), expVal);
    checkOutput({name, " error"}, int'(error), int'(expErr));
  endtask

  initial begin
    int busy;
    int lows;
    int highs;
    logic [15:0] r;

    tests    = 0;
    failures = 0;
    start    = 1'b0;
    bcd      = 16'h0000;
    rst      = 1'b1;

    vecs[0] = '{16'h1234, 14'd1234, 1'b0};
    vecs[1] = '{16'h9999, 14'd9999, 1'b0};
    vecs[2] = '{16'h0000, 14'd0,    1'b0};
    vecs[3] = '{16'h0001, 14'd1,    1'b0};
    vecs[4] = '{16'h1000, 14'd1000, 1'b0};
    vecs[5] = '{16'h12A4, 14'd1304, 1'b1};
    vecs[6] = '{16'h0042, 14'd42,   1'b0};

    // Reset state
    #2 rst = 1'b0;
    #1;
    checkOutput("reset value", int'(value), 0);
    checkOutput("reset ready", int'(ready), 1);
    checkOutput("reset error", int'(error), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Fixed vector table
    foreach (vecs[i])
      convertAndCheck($sformatf("vec%0d", i), vecs[i].bcd, int'(vecs[i].val), vecs[i].err);

    // Random operands against the reference model
    for (int i = 0; i < 30; i++) begin
      r = 16'($urandom);
      convertAndCheck($sformatf("rand %h", r), r, refValue(r), refError(r));
    end

    // Busy: start/bcd changes while running are ignored; value holds prior result
    convertAndCheck("pre-busy", 16'h1234, 1234, 1'b0);
    @(negedge clk);
    bcd   = 16'h0500;
    start = 1'b1;
    @(negedge clk);
    bcd = 16'h7777;
    checkOutput("busy ready low", int'(ready), 0);
    checkOutput("busy value held", int'(value), 1234);
    @(negedge clk);
    checkOutput("busy value held 2", int'(value), 1234);
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy value held 3", int'(value), 1234);
    busy = 0;
    while (ready == 1'b0 && busy < 20) begin
      busy++;
      @(negedge clk);
    end
    checkOutput("busy completes", busy, 2);
    checkOutput("busy value", int'(value), 500);
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      if (ready == 1'b1) highs++;
      @(negedge clk);
    end
    checkOutput("no second conversion", highs, 8);
    checkOutput("busy value stable", int'(value), 500);

    // Back-to-back with start held high
    @(negedge clk);
    bcd   = 16'h0123;
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      lows = 0;
      while (ready == 1'b0 && lows < 20) begin
        lows++;
        @(negedge clk);
      end
      checkOutput($sformatf("b2b%0d low cycles", k), lows, 4);
      checkOutput($sformatf("b2b%0d value", k), int'(value), 123);
      @(negedge clk);
      checkOutput($sformatf("b2b%0d ready pulse", k), int'(ready), 0);
    end
    start = 1'b0;
    busy = 0;
    while (ready == 1'b0 && busy < 20) begin
      busy++;
      @(negedge clk);
    end
    checkOutput("b2b drain", busy, 4);

    // Reset mid-conversion
    @(negedge clk);
    bcd   = 16'h4321;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst value", int'(value), 0);
    checkOutput("midrst ready", int'(ready), 1);
    checkOutput("midrst error", int'(error), 0);
    @(negedge clk);
    rst = 1'b1;
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready == 1'b1 && value == 14'd0) highs++;
    end
    checkOutput("midrst no completion", highs, 8);
    convertAndCheck("post-reset", 16'h0007, 7, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time %0t, expected completion before it", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Sequential 4-digit BCD to binary converter: accepts a packed BCD word and returns its binary value (0..9999) using one multiply-by-10-and-add step per clock. It is the inverse of the team's serial divide-by-10 digit extractor. It sits between the keypad/display digit registers and the binary datapath, so user-entered decimal values can be used arithmetically. It uses a start/ready handshake and flags non-decimal digits.

## Interface
- DIGITS, 4, number of BCD digits converted per request (most significant digit is processed first).
- WIDTH, 14, result width; must hold 10^DIGITS-1 (14 for 4 digits).
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  conversion request; sampled only while ready=1.
- bcd  input  4*DIGITS  packed BCD operand; bcd[4*DIGITS-1 -: 4] is the most significant digit; sampled only on the accepting edge.
- value  output  WIDTH  result register; holds the last completed result.
- ready  output  1  1 = idle and value valid; 0 = conversion in progress.
- error  output  1  1 = last completed conversion contained a digit >9; same validity as value.

## Operation
- Internal state:
  - sreg: a 4*DIGITS shift register.
  - acc: WIDTH-bit accumulator.
  - cnt: a down-counter wide enough to hold DIGITS.
  - err_acc: sticky flag.
  - State machine with IDLE and RUN; ready is 1 in IDLE and 0 in RUN.
- Reset (async, rst=0):
  - Outputs: value=0, ready=1, error=0.
  - Internal: sreg=0, acc=0, cnt=0, err_acc=0, state=IDLE.
  - Takes effect immediately, including mid-conversion. The partial result is discarded and no completion occurs.
- IDLE with start=1 at an edge:
  - Load sreg<=bcd, acc<=0, cnt<=DIGITS, err_acc<=0.
  - Go to RUN.
  - value and error keep their previous contents.
- IDLE with start=0: hold all state.
- Each RUN edge:
  - d = sreg top nibble.
  - acc <= (acc*10 + d) mod 2^WIDTH. Implement *10 as (acc<<3)+(acc<<1), truncated to WIDTH.
  - sreg <= sreg<<4, zero-filled.
  - err_acc <= err_acc | (d>9).
  - cnt <= cnt-1.
- Invalid digit (d>9):
  - The digit is still added at its raw value (10..15).
  - The error is reported; it does not abort the conversion.
- Completion, on the RUN edge where cnt==1:
  - value <= final acc (including this digit's contribution).
  - error <= final err_acc (including this digit's check).
  - Go to IDLE.
  - value and error change only at completion or reset, never with partial results.
- start while in RUN: ignored. Changes on bcd during RUN have no effect.
- Overflow: impossible with valid digits when WIDTH >= ceil(log2(10^DIGITS)). With invalid digits the result wraps mod 2^WIDTH.

## Timing
- Accept edge N (ready=1, start=1): ready is 0 after edge N.
- Digit k (k=1..DIGITS) is processed at edge N+k.
- At edge N+DIGITS: value and error are updated and ready returns to 1.
- Latency: value is valid DIGITS cycles after the accepting edge. ready is low for exactly DIGITS cycles.
- Back-to-back: with start held at 1, the next conversion is accepted at edge N+DIGITS+1. Throughput is one conversion per DIGITS+1 cycles.
- A start that rises in the same cycle ready rises is accepted at the following edge. It is not accepted at the completion edge itself.
- No combinational path from start or bcd to any output; all outputs are registered.

## Test plan
- Reset, then bcd=16'h1234 with a one-cycle start:
  - ready=0 for 4 cycles.
  - Then ready=1, value=14'd1234 (0x04D2), error=0.
- Corner values:
  - bcd=16'h9999: value=9999 (0x270F), error=0.
  - bcd=16'h0000: value=0, error=0.
  - bcd=16'h0001: value=1.
  - bcd=16'h1000: value=1000.
- Invalid digit, bcd=16'h12A4:
  - error=1, value=1304 (((1*10+2)*10+10)*10+4).
  - A following 16'h0042 conversion gives error=0, value=42.
- Busy behaviour:
  - Start 16'h0500; one cycle later drive start=1 with bcd=16'h7777 for 2 cycles, then release start.
  - Required: result value=500, and no second conversion is started.
  - value keeps its prior result (e.g. 1234) until the completion edge.
- start held high with bcd=16'h0123:
  - Consecutive conversions complete every 5 cycles.
  - ready pulses high for exactly 1 cycle between them.
  - value=123 each time.
- Reset mid-conversion: assert rst=0 two cycles after accepting 16'h4321.
  - Immediately: value=0, ready=1, error=0.
  - After release, no completion occurs.
  - A fresh 16'h0007 converts to 7.
